// File: rtl/cell_alloc_pkg.sv
// Shared constants, FSM state type and small helpers for the cell allocator.
package cell_alloc_pkg;

  localparam logic [15:0] UNDEF = 16'h0000;
  localparam logic [15:0] NIL   = 16'h0001;
  localparam logic        TRUE  = 1'b1;
  localparam logic        FALSE = 1'b0;
  localparam logic [15:0] UNIT  = 16'h0001;
  localparam logic [15:0] ZERO  = 16'h0000;

  typedef enum logic [0:0] {
    StIdle    = 1'b0,
    StPopWait = 1'b1
  } alloc_state_e;

  // True when addr lies in the given 256-word page.
  function automatic logic in_page(input logic [15:0] addr, input logic [7:0] page);
    return (addr[15:8] == page);
  endfunction

endpackage

// File: rtl/cell_alloc_if.sv
// Request/response bundle between a client and the cell allocator.
interface cell_alloc_if;

  logic        i_al;
  logic [15:0] i_adata;
  logic [15:0] o_aaddr;
  logic        i_fr;
  logic [15:0] i_faddr;
  logic        i_wr;
  logic [15:0] i_waddr;
  logic [15:0] i_wdata;
  logic        i_rd;
  logic [15:0] i_raddr;
  logic [15:0] o_rdata;
  logic        o_err;

  modport master (
    output i_al, i_adata, i_fr, i_faddr, i_wr, i_waddr, i_wdata, i_rd, i_raddr,
    input  o_aaddr, o_rdata, o_err
  );

  modport slave (
    input  i_al, i_adata, i_fr, i_faddr, i_wr, i_waddr, i_wdata, i_rd, i_raddr,
    output o_aaddr, o_rdata, o_err
  );

endinterface

// File: rtl/cell_alloc_ram_cells.sv
// Cell storage: one synchronous read-first read port and one write port.
module ram_cells #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          i_clk,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [15:0]   o_rdata,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [15:0]   i_wdata
);

  logic [15:0] r_mem [DEPTH];
  logic [15:0] r_rdata;

  // Read-first: a same-cycle write to the read address returns the old word.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cell_alloc.sv
// Cell allocator: LIFO free list threaded through the cells plus a bump pointer.
module cell_alloc
  import cell_alloc_pkg::*;
#(
  parameter logic [15:0] BASE  = 16'h5000,
  parameter int unsigned DEPTH = 256
) (
  input logic         i_clk,
  input logic         i_rst,
  cell_alloc_if.slave io_bus
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned TW   = AW + 1;
  localparam logic [7:0]  PAGE = BASE[15:8];

  alloc_state_e  r_state;
  alloc_state_e  w_state_next;
  logic [15:0]   r_head;
  logic [TW-1:0] r_top;
  logic [15:0]   r_aaddr;
  logic [15:0]   r_rdata_hold;
  logic          r_rd_last;
  logic          r_err;

  logic          w_pop_wait;
  logic [15:0]   w_link;
  logic          w_pop;
  logic          w_bump;
  logic          w_full;
  logic          w_err;
  logic          w_accept;
  logic [15:0]   w_bump_addr;
  logic [15:0]   w_new_addr;
  logic          w_ram_re;
  logic [AW-1:0] w_ram_raddr;
  logic          w_ram_we;
  logic [AW-1:0] w_ram_waddr;
  logic [15:0]   w_ram_wdata;
  logic [15:0]   w_ram_q;

  ram_cells #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_re    (w_ram_re),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_ram_q),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata)
  );

  // FSM state register; reset drops any pending pop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  // Next state: an accepted pop spends one cycle waiting for the head link.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (w_accept && w_pop) w_state_next = StPopWait;
      StPopWait: w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  // Arbitration, error detection and RAM port steering.
  always_comb begin
    w_pop_wait  = (r_state == StPopWait);
    // While a pop is in flight the true head is the link just read from RAM.
    w_link      = w_pop_wait ? w_ram_q : r_head;
    w_pop       = io_bus.i_al && !io_bus.i_fr && !w_pop_wait && (r_head != NIL);
    w_bump      = io_bus.i_al && !io_bus.i_fr && !w_pop_wait && (r_head == NIL);
    w_full      = (r_top == TW'(DEPTH));
    w_bump_addr = BASE | 16'(r_top);
    w_new_addr  = io_bus.i_fr ? io_bus.i_faddr : (w_pop ? r_head : w_bump_addr);

    w_err = (w_bump && w_full)
         || ((io_bus.i_al || io_bus.i_fr) && io_bus.i_wr)
         || (w_pop && io_bus.i_rd)
         || (io_bus.i_al && !io_bus.i_fr && w_pop_wait)
         || (io_bus.i_fr && !in_page(io_bus.i_faddr, PAGE))
         || (io_bus.i_wr && !in_page(io_bus.i_waddr, PAGE))
         || (io_bus.i_rd && !in_page(io_bus.i_raddr, PAGE))
         || (io_bus.i_fr && (16'(io_bus.i_faddr[7:0]) >= 16'(r_top)));
    w_accept = !w_err;

    w_ram_we    = 1'b0;
    w_ram_waddr = '0;
    w_ram_wdata = '0;
    w_ram_re    = 1'b0;
    w_ram_raddr = '0;
    if (w_accept) begin
      // At most one writer survives the error rules.
      if (io_bus.i_al) begin
        w_ram_we    = 1'b1;
        w_ram_waddr = w_new_addr[AW-1:0];
        w_ram_wdata = io_bus.i_adata;
      end else if (io_bus.i_fr) begin
        w_ram_we    = 1'b1;
        w_ram_waddr = io_bus.i_faddr[AW-1:0];
        w_ram_wdata = w_link;
      end else if (io_bus.i_wr) begin
        w_ram_we    = 1'b1;
        w_ram_waddr = io_bus.i_waddr[AW-1:0];
        w_ram_wdata = io_bus.i_wdata;
      end
      // Read-first RAM lets the pop fetch the old link while i_adata overwrites it.
      if (w_pop) begin
        w_ram_re    = 1'b1;
        w_ram_raddr = r_head[AW-1:0];
      end else if (io_bus.i_rd) begin
        w_ram_re    = 1'b1;
        w_ram_raddr = io_bus.i_raddr[AW-1:0];
      end
    end
  end

  // Head, bump pointer and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head       <= NIL;
      r_top        <= '0;
      r_aaddr      <= UNDEF;
      r_rdata_hold <= UNDEF;
      r_rd_last    <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_err     <= w_err;
      r_rd_last <= w_accept && io_bus.i_rd;
      if (r_rd_last) r_rdata_hold <= w_ram_q;
      if (w_accept && io_bus.i_fr && !io_bus.i_al) r_head <= io_bus.i_faddr;
      else if (w_pop_wait)                         r_head <= w_ram_q;
      if (w_accept && w_bump)      r_top   <= r_top + TW'(1);
      if (w_accept && io_bus.i_al) r_aaddr <= w_new_addr;
    end
  end

  // Fresh RAM data on the cycle after a read, otherwise the held value.
  always_comb begin
    io_bus.o_rdata = r_rd_last ? w_ram_q : r_rdata_hold;
    io_bus.o_aaddr = r_aaddr;
    io_bus.o_err   = r_err;
  end

endmodule

// File: tb/tb_cell_alloc.sv
module tb_cell_alloc;

  localparam logic [15:0] BASE  = 16'h5000;
  localparam int          DEPTH = 256;
  localparam logic [15:0] NILA  = 16'h0001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cell_alloc_if bus ();

  cell_alloc #(
    .BASE  (BASE),
    .DEPTH (DEPTH)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  // Reference model: cell contents, free list as a LIFO queue, owned cells.
  logic [15:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  logic [15:0] m_fl    [$];
  logic [15:0] m_owned [$];
  int          m_top;
  bit          m_popwait;
  logic [15:0] exp_aaddr;
  logic [15:0] exp_rdata;
  bit          exp_rknown;
  logic        exp_err;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic model_reset();
    m_fl.delete();
    m_owned.delete();
    m_top      = 0;
    m_popwait  = 0;
    exp_aaddr  = 16'h0000;
    exp_rdata  = 16'h0000;
    exp_rknown = 1;
    exp_err    = 1'b0;
  endtask

  task automatic drive_idle();
    bus.i_al = 0; bus.i_adata = 0; bus.i_fr = 0; bus.i_faddr = 0;
    bus.i_wr = 0; bus.i_waddr = 0; bus.i_wdata = 0; bus.i_rd = 0; bus.i_raddr = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    #2;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock of stimulus; the model predicts the outputs after the edge.
  task automatic step(input bit al, input logic [15:0] adata, input bit fr,
                      input logic [15:0] faddr, input bit wr, input logic [15:0] waddr,
                      input logic [15:0] wdata, input bit rd, input logic [15:0] raddr);
    bit          err;
    bit          pop;
    int          fo;
    logic [15:0] rv;
    bit          rk;
    logic [15:0] a;
    bus.i_al = al; bus.i_adata = adata; bus.i_fr = fr; bus.i_faddr = faddr;
    bus.i_wr = wr; bus.i_waddr = waddr; bus.i_wdata = wdata; bus.i_rd = rd;
    bus.i_raddr = raddr;
    fo  = int'(faddr[7:0]);
    pop = al && !fr && !m_popwait && (m_fl.size() != 0);
    err = (al && !fr && m_popwait)
       || (al && !fr && !m_popwait && m_fl.size() == 0 && m_top == DEPTH)
       || ((al || fr) && wr) || (pop && rd)
       || (fr && faddr[15:8] != BASE[15:8]) || (wr && waddr[15:8] != BASE[15:8])
       || (rd && raddr[15:8] != BASE[15:8]) || (fr && fo >= m_top);
    m_popwait = 0;
    if (!err) begin
      rv = m_mem[raddr[7:0]];
      rk = m_known[raddr[7:0]];
      if (al && fr) begin
        exp_aaddr = faddr;
        m_mem[fo] = adata; m_known[fo] = 1;
      end else if (al) begin
        if (pop) begin
          a = m_fl.pop_back();
          m_popwait = 1;
        end else begin
          a = BASE | 16'(m_top);
          m_top++;
        end
        exp_aaddr = a;
        m_mem[a[7:0]] = adata; m_known[a[7:0]] = 1;
        m_owned.push_back(a);
      end else if (fr) begin
        m_mem[fo] = (m_fl.size() != 0) ? m_fl[$] : NILA;
        m_known[fo] = 1;
        m_fl.push_back(faddr);
        for (int i = 0; i < m_owned.size(); i++)
          if (m_owned[i] == faddr) begin m_owned.delete(i); break; end
      end
      if (wr) begin m_mem[waddr[7:0]] = wdata; m_known[waddr[7:0]] = 1; end
      if (rd) begin exp_rdata = rv; exp_rknown = rk; end
    end
    exp_err = err;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    #2;
    n_cmp++; if (bus.o_aaddr !== 16'h0000) begin n_bad++;
      $display("FAIL reset_aaddr got %h want 0000", bus.o_aaddr); end
    n_cmp++; if (bus.o_rdata !== 16'h0000) begin n_bad++;
      $display("FAIL reset_rdata got %h want 0000", bus.o_rdata); end
    n_cmp++; if (bus.o_err !== 1'b0) begin n_bad++;
      $display("FAIL reset_err got %b want 0", bus.o_err); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_read_write();
    step(0, 0, 0, 0, 1, 16'h502A, 16'h81A4, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 16'h502A);
    n_cmp++; if (bus.o_rdata !== 16'h81A4) begin n_bad++;
      $display("FAIL rw_rdata got %h want 81a4", bus.o_rdata); end
    n_cmp++; if (bus.o_err !== 1'b0) begin n_bad++;
      $display("FAIL rw_err got %b want 0", bus.o_err); end
    step(0, 0, 0, 0, 1, 16'h5090, 16'h8539, 0, 0);
    step(0, 0, 0, 0, 1, 16'h5090, 16'h8168, 1, 16'h5090);
    n_cmp++; if (bus.o_rdata !== 16'h8539) begin n_bad++;
      $display("FAIL rbw_old got %h want 8539", bus.o_rdata); end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.o_rdata !== 16'h8539) begin n_bad++;
      $display("FAIL rdata_hold got %h want 8539", bus.o_rdata); end
    step(0, 0, 0, 0, 0, 0, 0, 1, 16'h5090);
    n_cmp++; if (bus.o_rdata !== 16'h8168) begin n_bad++;
      $display("FAIL rbw_new got %h want 8168", bus.o_rdata); end
  endtask

  task automatic test_alloc_free();
    logic [15:0] want [3];
    want[0] = 16'h5000; want[1] = 16'h5001; want[2] = 16'h5002;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 16'hA000 + 16'(i), 0, 0, 0, 0, 0, 0, 0);
      n_cmp++; if (bus.o_aaddr !== want[i]) begin n_bad++;
        $display("FAIL bump_%0d got %h want %h", i, bus.o_aaddr, want[i]); end
    end
    step(0, 0, 1, 16'h5002, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.o_err !== 1'b0) begin n_bad++;
      $display("FAIL free_err got %b want 0", bus.o_err); end
    step(0, 0, 1, 16'h5001, 0, 0, 0, 0, 0);
    step(1, 16'hB001, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.o_aaddr !== 16'h5001) begin n_bad++;
      $display("FAIL pop_head got %h want 5001", bus.o_aaddr); end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 16'hB002, 1, 16'h5000, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.o_aaddr !== 16'h5000) begin n_bad++;
      $display("FAIL alloc_free_bypass got %h want 5000", bus.o_aaddr); end
    step(1, 16'hB003, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.o_aaddr !== 16'h5002) begin n_bad++;
      $display("FAIL pop_link got %h want 5002", bus.o_aaddr); end
    step(0, 0, 0, 0, 0, 0, 0, 1, 16'h5002);
    n_cmp++; if (bus.o_rdata !== 16'hB003) begin n_bad++;
      $display("FAIL alloc_data got %h want b003", bus.o_rdata); end
  endtask

  task automatic test_exhaust();
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, 16'(i), 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.o_aaddr !== 16'h50FF || bus.o_err !== 1'b0) begin n_bad++;
      $display("FAIL last_bump got %h/%b want 50ff/0", bus.o_aaddr, bus.o_err); end
    step(1, 16'hDEAD, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.o_err !== 1'b1 || bus.o_aaddr !== 16'h50FF) begin n_bad++;
      $display("FAIL full_err got %b/%h want 1/50ff", bus.o_err, bus.o_aaddr); end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.o_err !== 1'b0) begin n_bad++;
      $display("FAIL err_pulse got %b want 0", bus.o_err); end
    step(0, 0, 1, 16'h6000, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.o_err !== 1'b1) begin n_bad++;
      $display("FAIL bad_page got %b want 1", bus.o_err); end
    step(1, 16'h1111, 0, 0, 1, 16'h5003, 16'h2222, 0, 0);
    n_cmp++; if (bus.o_err !== 1'b1) begin n_bad++;
      $display("FAIL alloc_wr got %b want 1", bus.o_err); end
  endtask

  task automatic test_pop_wait();
    do_reset();
    step(1, 16'h0C00, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 16'h5000, 0, 0, 0, 0, 0);
    step(1, 16'h0C01, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.o_aaddr !== 16'h5000) begin n_bad++;
      $display("FAIL pw_pop got %h want 5000", bus.o_aaddr); end
    step(1, 16'h0C02, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.o_err !== 1'b1 || bus.o_aaddr !== 16'h5000) begin n_bad++;
      $display("FAIL pw_alloc got %b/%h want 1/5000", bus.o_err, bus.o_aaddr); end
    step(0, 0, 1, 16'h5000, 0, 0, 0, 0, 0);
    step(1, 16'h0C03, 0, 0, 0, 0, 0, 1, 16'h5000);
    n_cmp++; if (bus.o_err !== 1'b1) begin n_bad++;
      $display("FAIL pop_rd got %b want 1", bus.o_err); end
    step(0, 0, 1, 16'h5009, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.o_err !== 1'b1) begin n_bad++;
      $display("FAIL free_above_top got %b want 1", bus.o_err); end
    step(0, 0, 0, 0, 1, 16'h5010, 16'h1234, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 16'h5010);
    step(1, 16'h0C04, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.o_rdata !== 16'h1234 || bus.o_aaddr !== 16'h5000) begin n_bad++;
      $display("FAIL pre_rst got %h/%h want 1234/5000", bus.o_rdata, bus.o_aaddr); end
    // Reset lands in the pop-wait cycle.
    rst = 1'b1;
    #2;
    n_cmp++; if (bus.o_aaddr !== 16'h0000 || bus.o_rdata !== 16'h0000) begin n_bad++;
      $display("FAIL mid_rst got %h/%h want 0000/0000", bus.o_aaddr, bus.o_rdata); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(1, 16'h0C05, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.o_aaddr !== 16'h5000 || bus.o_err !== 1'b0) begin n_bad++;
      $display("FAIL post_rst got %h/%b want 5000/0", bus.o_aaddr, bus.o_err); end
  endtask

  task automatic test_random();
    bit          al, fr, wr, rd;
    logic [15:0] fa, wa, ra;
    int          r;
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      step(0, 0, 0, 0, 1, BASE | 16'(i), 16'($urandom), 0, 0);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(299) == 0) begin
        do_reset();
        n_cmp++; if (bus.o_aaddr !== exp_aaddr || bus.o_rdata !== exp_rdata) begin n_bad++;
          $display("FAIL rnd_rst got %h/%h want %h/%h", bus.o_aaddr, bus.o_rdata,
                   exp_aaddr, exp_rdata); end
      end
      al = ($urandom_range(2) == 0);
      fr = 0; fa = 0;
      r = $urandom_range(7);
      if (r < 2 && m_owned.size() != 0) begin
        fr = 1; fa = m_owned[$urandom_range(m_owned.size() - 1)];
      end else if (r == 2) begin
        fr = 1; fa = {8'($urandom_range(8'h51, 8'hFF)), 8'($urandom)};
      end else if (r == 3 && m_top < DEPTH) begin
        fr = 1; fa = BASE | 16'($urandom_range(DEPTH - 1, m_top));
      end
      wr = ($urandom_range(4) == 0);
      wa = 0;
      if (wr) begin
        if ($urandom_range(15) == 0) wa = 16'h4F00 | 16'($urandom_range(255));
        else if (m_owned.size() != 0) wa = m_owned[$urandom_range(m_owned.size() - 1)];
        else if (m_top < DEPTH) wa = BASE | 16'($urandom_range(DEPTH - 1, m_top));
        else wr = 0;
      end
      rd = ($urandom_range(2) == 0);
      ra = ($urandom_range(15) == 0) ? 16'h6100 : (BASE | 16'($urandom_range(255)));
      step(al, 16'($urandom), fr, fa, wr, wa, 16'($urandom), rd, ra);
      n_cmp++; if (bus.o_err !== exp_err) begin n_bad++;
        $display("FAIL rnd_err cyc %0d got %b want %b", c, bus.o_err, exp_err); end
      n_cmp++; if (bus.o_aaddr !== exp_aaddr) begin n_bad++;
        $display("FAIL rnd_aaddr cyc %0d got %h want %h", c, bus.o_aaddr, exp_aaddr); end
      if (exp_rknown) begin
        n_cmp++; if (bus.o_rdata !== exp_rdata) begin n_bad++;
          $display("FAIL rnd_rdata cyc %0d got %h want %h", c, bus.o_rdata, exp_rdata); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 16'h0000; m_known[i] = 0; end
    model_reset();
    drive_idle();
    #3;
    test_reset();
    test_read_write();
    test_alloc_free();
    test_exhaust();
    test_pop_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cell_alloc.md
CELL_ALLOC -- requirements
Module: cell_alloc

Interface
REQ-001 SHALL have parameter BASE, default 16'h5000, meaning word address of RAM offset 0; page is BASE[15:8].
REQ-002 SHALL have parameter DEPTH, default 256, meaning number of 16-bit cells; DEPTH SHALL be a power of two and at most 256.
REQ-003 SHALL have ports:
- i_clk  in  1  system clock, single clock domain.
- i_rst  in  1  asynchronous, active-high reset.
- i_al  in  1  allocate request.
- i_adata  in  16  initial contents of the allocated cell.
- o_aaddr  out  16  allocated address.
- i_fr  in  1  free request.
- i_faddr  in  16  address to free.
- i_wr  in  1  write request.
- i_waddr  in  16  write address.
- i_wdata  in  16  write data.
- i_rd  in  1  read request.
- i_raddr  in  16  read address.
- o_rdata  out  16  read data.
- o_err  out  1  protocol/resource error pulse.

Function
REQ-004 SHALL accept at most one request of each kind per cycle; results SHALL appear on the cycle after the request edge.
REQ-005 o_rdata SHALL become the cell value sampled before any same-cycle write (read-before-write); it SHALL hold until the next accepted read.
REQ-006 A write SHALL store i_wdata at offset i_waddr[7:0]; a write and a read to the same address in one cycle SHALL return the old value.
REQ-007 Allocation SHALL use three sources, in this priority:
- a same-cycle i_fr: return i_faddr, free list unchanged;
- else free-list head: pop it;
- else bump pointer top: return BASE|top, then top+1.
REQ-008 The allocated cell SHALL be written with i_adata; o_aaddr SHALL hold until the next allocation.
REQ-009 Free (no same-cycle alloc) SHALL write the current head link into the freed cell and make i_faddr the head (LIFO); an empty list SHALL be encoded as NIL (16'h0001).
REQ-010 A pop SHALL read the head cell's link through the RAM read port.
REQ-011 FSM states: IDLE, POP_WAIT.
- IDLE to POP_WAIT on a pop.
- POP_WAIT to IDLE unconditionally.
- In POP_WAIT, head SHALL be loaded from the RAM output.
- A free in POP_WAIT SHALL link to that RAM output value.
REQ-012 o_err SHALL pulse high for one cycle, with no state change for the offending request, on:
- alloc with list empty and top==DEPTH;
- i_al or i_fr together with i_wr;
- a pop together with i_rd;
- i_al without i_fr while in POP_WAIT;
- an address whose [15:8] is not the BASE page;
- i_faddr offset >= top.
REQ-013 top SHALL be width log2(DEPTH)+1 and SHALL saturate at DEPTH, never wrapping.

Reset
REQ-014 i_rst SHALL asynchronously force:
- o_aaddr = o_rdata = UNDEF (16'h0000);
- o_err = 0, head = NIL, top = 0, state = IDLE.
RAM contents are not cleared.
REQ-015 Reset during POP_WAIT SHALL discard the pending pop; the first cycle after reset release SHALL accept requests.

Structure
REQ-016 The constants UNDEF, NIL, TRUE, FALSE, UNIT and ZERO SHALL live in the shared constants include, not in this module.
REQ-017 The cell RAM SHALL be one sub-module, ram_cells, with one synchronous read port and one write port (ice40 EBR inferable).
REQ-018 cell_alloc SHALL contain only the FSM, the head/top registers and the arbitration logic.

Verification
REQ-019 Write 16'h81A4 to 16'h502A, then read it: o_rdata = 16'h81A4 one cycle later, o_err = 0.
REQ-020 Read 16'h5090 holding 16'h8539 while writing 16'h8168 to it: o_rdata = 16'h8539; a following read returns 16'h8168.
REQ-021 Reset, then alloc, alloc, alloc: o_aaddr = 16'h5000, 16'h5001, 16'h5002.
REQ-022 Then free 16'h5002, free 16'h5001, alloc, idle cycle, free 16'h5000 with same-cycle alloc, alloc: o_aaddr = 16'h5001, 16'h5000, 16'h5002.
REQ-023 With DEPTH allocations done, one more alloc: o_err = 1 for exactly one cycle and o_aaddr unchanged; free of 16'h6000 also pulses o_err.
REQ-024 Alloc immediately after a pop (POP_WAIT, no free): o_err pulses; asserting i_rst mid-sequence returns o_aaddr/o_rdata to 16'h0000 and the next alloc yields 16'h5000.
